// File: rtl/sad_block_sequencer.sv
// Block sum-of-absolute-differences sequencer: accumulates |a-b| over four nibbles
// per accepted word pair for BLOCK_LEN pairs, then presents the block result.
module sad_block_sequencer #(
  parameter int unsigned BLOCK_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] input_a,
  input  logic [15:0] input_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] output_sum,
  output logic [7:0]  word_count,
  output logic        busy
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = WORD_W / NIB_W;
  localparam int unsigned PAIR_W  = 6;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BLOCK_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [PAIR_W-1:0]   pair_sad_c;
  logic                transfer_c;

  function automatic logic [NIB_W-1:0] nib_absdiff(input logic [NIB_W-1:0] x,
                                                   input logic [NIB_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  // Per-pair SAD: four unsigned nibble distances, summed to at most 60
  always_comb begin
    pair_sad_c = '0;
    for (int i = 0; i < int'(NUM_NIB); i++) begin
      pair_sad_c = pair_sad_c + PAIR_W'(nib_absdiff(input_a[i*NIB_W +: NIB_W],
                                                     input_b[i*NIB_W +: NIB_W]));
    end
  end

  assign transfer_c = in_valid & in_ready_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    count_d     = count_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      ST_ACCUM: begin
        if (transfer_c) begin
          acc_d   = acc_q + WORD_W'(pair_sad_c);
          count_d = count_q + CNT_W'(1);
          if (count_d == LAST_COUNT) begin
            state_d = ST_DONE;
            sum_d   = acc_d;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign output_sum = sum_q;
  assign word_count = count_q;
  assign busy       = busy_q;

endmodule
